// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: branch redirect, stall hold, halt drain and halted park.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_dec,
  output logic [15:0] pc,
  output logic [15:0] pc_plus_2,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fetch_valid_c, flush_ifid_c, flush_idex_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    fetch_valid_c = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idex_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d         = branch_target;
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_dec) begin
          fetch_valid_c = 1'b1;
          state_d       = DRAIN;
          cnt_d         = DRAIN_LOAD;
        end else begin
          fetch_valid_c = 1'b1;
          pc_d          = pc_q + 16'd2;
        end
      end
      DRAIN: begin
        flush_ifid_c = 1'b1;
        if (branch_taken) begin
          // A resolved branch means the HLT was on a wrong path: resume fetching.
          pc_d         = branch_target;
          flush_idex_c = 1'b1;
          state_d      = RUN;
          cnt_d        = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign pc          = pc_q;
  assign pc_plus_2   = pc_q + 16'd2;
  assign fetch_valid = fetch_valid_c & ~rst;
  assign flush_ifid  = flush_ifid_c & ~rst;
  assign flush_idex  = flush_idex_c & ~rst;
  assign halted      = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  // Halted ignores all inputs, so a branch there is not a redirect.
  always_comb begin
    redirect_cnt_d = sat_inc(redirect_cnt_q, branch_taken && (state_q != HALTED));
    stall_cnt_d    = sat_inc(stall_cnt_q, (state_q == RUN) && stall && !branch_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter DRAIN_CYCLES, default 3: cycles spent draining the pipeline after a halt before halted asserts; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall  input  1  hazard-unit stall request; freezes the PC.
REQ-006 branch_taken  input  1  branch resolved taken (Branch qualified by BranchImm/BranchReg).
REQ-007 branch_target  input  16  resolved branch/jump target address.
REQ-008 halt_dec  input  1  HLT instruction present in decode.
REQ-009 pc  output  16  current fetch address, registered.
REQ-010 pc_plus_2  output  16  pc + 2, modulo 2^16, combinational.
REQ-011 fetch_valid  output  1  fetched instruction this cycle is valid.
REQ-012 flush_ifid  output  1  force IF/ID to a bubble at the next edge.
REQ-013 flush_idex  output  1  force ID/EX to a bubble at the next edge.
REQ-014 halted  output  1  pipeline drained and fetch stopped.

Function
REQ-015 The block SHALL implement three states: RUN, DRAIN, HALTED.
REQ-016 Per-edge priority in RUN SHALL be: branch_taken > stall > halt_dec > normal advance.
REQ-017 Normal advance in RUN SHALL load pc <= pc_plus_2.
REQ-018 On branch_taken=1, pc SHALL load branch_target at the edge, and flush_ifid and flush_idex SHALL be 1 combinationally in that same cycle.
REQ-019 When branch_taken=1 and stall=1 together, the branch SHALL win: the PC redirects and both flushes assert.
REQ-020 On stall=1 with branch_taken=0, pc SHALL hold, and both flushes SHALL be 0.
REQ-021 On halt_dec=1 in RUN, with no branch and no stall, pc SHALL hold and the state SHALL go to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
REQ-022 In DRAIN, pc SHALL hold, fetch_valid SHALL be 0, and flush_ifid SHALL be 1; the counter SHALL decrement each edge, and at 0 the state SHALL go to HALTED.
REQ-023 branch_taken=1 in DRAIN SHALL cancel the halt: pc <= branch_target, both flushes 1, state returns to RUN, counter cleared.
REQ-024 In HALTED, halted SHALL be 1 and fetch_valid 0; pc SHALL hold and all inputs SHALL be ignored until rst.
REQ-025 fetch_valid SHALL be 1 in RUN when stall=0 and branch_taken=0, and 0 otherwise.
REQ-026 Reaching pc=16'hFFFE and advancing SHALL wrap pc to 16'h0000 with no flag.
REQ-027 branch_target SHALL be used unmodified; an odd target SHALL NOT be corrected.

Reset
REQ-028 While rst=1, the block SHALL force immediately (asynchronously): pc=RESET_PC, state RUN, drain counter 0, halted=0.
REQ-029 While rst=1, fetch_valid, flush_ifid and flush_idex SHALL be 0.
REQ-030 rst asserted during DRAIN or HALTED SHALL return the block to RUN at RESET_PC.
REQ-031 The first edge after rst deasserts SHALL perform a normal RUN evaluation.

Configuration
REQ-032 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs redirect_cnt[15:0] and stall_cnt[15:0].
REQ-033 redirect_cnt SHALL increment on each edge with branch_taken=1 and stall_cnt on each RUN edge with stall=1 and branch_taken=0; both SHALL saturate at 16'hFFFF and reset to 0.
REQ-034 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Release rst, run 4 edges with no inputs -> pc sequence 0000, 0002, 0004, 0006, 0008; fetch_valid=1.
REQ-036 At pc=0x0010, assert branch_taken with target 0x0040 -> same cycle flush_ifid=flush_idex=1; next pc=0x0040.
REQ-037 At pc=0x0020, assert stall for 2 cycles with branch_taken=1 in the 2nd -> pc=0x0020 after the 1st edge and 0x0080 (target) after the 2nd; flushes only in the 2nd cycle.
REQ-038 Assert halt_dec at pc=0x0030 -> DRAIN for 3 edges, then halted=1 with pc=0x0030; later branch_taken is ignored.
REQ-039 Assert halt_dec, then branch_taken with target 0x0100 in the 2nd DRAIN cycle -> halted stays 0; pc=0x0100; state RUN.
REQ-040 With the PC driven to 0xFFFE, advance -> pc=0x0000; with FETCH_PERF_CNT_EN, 3 redirects -> redirect_cnt=3; then rst -> 0.
